// File: rtl/sipo_deframer.sv
// Serial-in/parallel-out deframer: assembles N-bit words from a bit stream and
// hands them to a stallable consumer through a one-word holding register.
module sipo_deframer #(
  parameter int N         = 8,
  parameter bit MSB_FIRST = 1'b0,
  parameter int CW        = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          shift_en,
  input  logic          serial_in,
  input  logic          en_o,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [N-1:0]  parallel_out,
  output logic [CW-1:0] bit_cnt,
  output logic          overflow
);

  logic [N-1:0] sreg, sreg_nxt, hold;
  logic         last, take, drain;

  if (MSB_FIRST) begin : g_msb
    assign sreg_nxt = {sreg[N-2:0], serial_in};
  end else begin : g_lsb
    assign sreg_nxt = {serial_in, sreg[N-1:1]};
  end

  // last: this edge samples the Nth bit; the word is sreg_nxt
  assign last  = shift_en && (bit_cnt == CW'(N-1));
  assign drain = out_valid && out_ready;
  assign take  = last && (!out_valid || out_ready);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sreg      <= '0;
      bit_cnt   <= '0;
      hold      <= '0;
      out_valid <= 1'b0;
      overflow  <= 1'b0;
    end else if (clr) begin
      sreg      <= '0;
      bit_cnt   <= '0;
      hold      <= '0;
      out_valid <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      if (shift_en) begin
        sreg    <= sreg_nxt;
        bit_cnt <= last ? '0 : bit_cnt + 1'b1;
      end
      // a completed word either lands in hold or is dropped; hold never moves under stall
      if (take) begin
        hold      <= sreg_nxt;
        out_valid <= 1'b1;
      end else if (last) begin
        overflow  <= 1'b1;
      end else if (drain) begin
        out_valid <= 1'b0;
      end
    end
  end

  assign parallel_out = en_o ? hold : '0;

endmodule

// File: doc/sipo_deframer.md
Name: sipo_deframer

Overview:
- Parametrised serial-in/parallel-out deserialiser with bit counter, word framing, a one-word output holding register, and a valid/ready output handshake.
- Generalises the basic SIPO shifter in four ways: configurable width, selectable bit order, a sync clear, and sticky overflow detection.
- Sits between a serial receive front-end (SPI-like/bit-serial link) and a parallel consumer that may stall.

Parameters:
- N, 8, word width in bits; legal range is N >= 2.
- MSB_FIRST, 0, bit order of the input.
  - 0: first received bit lands in parallel_out[0]; shift is toward LSB, new bit enters at MSB.
  - 1: first received bit lands in parallel_out[N-1]; shift is toward MSB, new bit enters at LSB.
- CW, $clog2(N), width of bit_cnt.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- clr  in  1  synchronous clear; aborts the partial word and flushes the output.
- shift_en  in  1  samples serial_in this cycle.
- serial_in  in  1  serial data bit.
- en_o  in  1  output enable; when 0, parallel_out is forced to 0.
- out_valid  out  1  holding register contains an unconsumed word.
- out_ready  in  1  consumer accepts the word when out_valid && out_ready.
- parallel_out  out  N  holding register, gated by en_o (combinational gate).
- bit_cnt  out  CW  number of bits received in the current partial word (0..N-1).
- overflow  out  1  sticky flag: a completed word was dropped.

Behaviour:
- Reset (rst=0, async): sreg=0, bit_cnt=0, hold=0, out_valid=0, overflow=0. parallel_out=0.
- Priority each cycle: clr > shift_en.
- clr=1: sreg, bit_cnt, out_valid and overflow are cleared next edge; hold is cleared to 0; shift_en is ignored.
- Shift (shift_en=1, clr=0):
  - MSB_FIRST=0: sreg <= {serial_in, sreg[N-1:1]}.
  - MSB_FIRST=1: sreg <= {sreg[N-2:0], serial_in}.
  - bit_cnt increments.
- Word completion: shift_en=1 while bit_cnt==N-1.
  - The assembled word w is the shifted value including this cycle's bit.
  - bit_cnt wraps to 0; sreg keeps w, but w is irrelevant for the next word.
- Transfer rule at completion: if out_valid==0 or (out_valid && out_ready) in the same cycle, then hold <= w and out_valid <= 1 next cycle. Latency is 1 clock from the last bit's edge.
- Overflow at completion: if out_valid==1 && out_ready==0, w is dropped, hold and out_valid are unchanged, and overflow <= 1. overflow stays set until clr or reset.
- Drain: out_valid && out_ready with no completion in the same cycle gives out_valid <= 0 next cycle. hold retains its value (still visible through en_o).
- shift_en=0: sreg and bit_cnt hold; the handshake still operates.
- out_valid is independent of en_o. en_o gates data only and never blocks the handshake.
- Stability: hold and out_valid must not change while out_valid=1 && out_ready=0, except on clr or reset.
- Async reset mid-word discards the partial word. The first shift after release is bit 0 of a new word.
- shift_en gaps within a word are allowed; the word completes only on the Nth sampled bit.

Test Plan:
- N=4, MSB_FIRST=0, en_o=1, out_ready=1; shift bits 1,0,1,1 on consecutive cycles -> one cycle after the 4th bit: out_valid=1, parallel_out=4'hD, bit_cnt=0.
- Same stimulus with MSB_FIRST=1 -> parallel_out=4'hB. Same stimulus with en_o=0 -> parallel_out=0 and out_valid=1.
- N=4, out_ready=0; send 4'hD then the bits for 4'h3 -> overflow=1 after the second word, parallel_out stays 4'hD. Then pulse clr -> overflow=0, out_valid=0, parallel_out=0.
- Back-to-back words with out_ready asserted on the completion cycle of word 2 -> word 2 replaces word 1 with no overflow and out_valid stays 1 across the boundary.
- Shift 2 bits, deassert rst for 1 cycle, release, then shift 4 bits 0,1,1,0 (MSB_FIRST=0) -> parallel_out=4'h6; the partial bits before reset are absent.
- Shift bits with shift_en gaps (1 on, 3 off, repeated) -> bit_cnt advances only on enabled cycles; the word is correct and completes on the 4th enabled bit.
